// File: rtl/dac_spi_pkg.sv
// Shared definitions for the DAC SPI output stage.
//   dac_state_t      : serializer FSM states
//   CMD_BITS         : width of the command header sent ahead of each code
//   DAC_CMD_DEFAULT  : command header used unless overridden
//   frame_bits()     : total SPI frame length for a given DAC resolution
package dac_spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2,
        ST_GAP  = 2'd3
    } dac_state_t;

    localparam int             CMD_BITS        = 4;
    localparam logic [3:0]     DAC_CMD_DEFAULT = 4'b0011;

    function automatic int frame_bits(input int dac_bits);
        return CMD_BITS + dac_bits;
    endfunction

endpackage

// File: rtl/dac_code_conv.sv
// Combinational conversion of a two's complement sample to a DAC code:
// round to nearest at DAC resolution, saturate positive overflow, and
// flip the MSB to produce offset binary.
//   sample : signed input sample, DATA_WIDTH bits
//   code   : offset-binary DAC code, DAC_BITS bits
module dac_code_conv #(
    parameter int DATA_WIDTH = 16,
    parameter int DAC_BITS   = 12
) (
    input  logic [DATA_WIDTH-1:0] sample,
    output logic [DAC_BITS-1:0]   code
);

    // Half an LSB of the DAC code, expressed at input resolution.
    localparam logic [DATA_WIDTH:0] ROUND =
        {{DATA_WIDTH{1'b0}}, 1'b1} << (DATA_WIDTH - DAC_BITS - 1);

    logic [DATA_WIDTH:0]   sum;
    logic                  overflow;
    logic [DATA_WIDTH-1:0] sat;
    logic                  unused_low;

    // Sign-extend by one bit so the rounding add cannot wrap.
    assign sum = {sample[DATA_WIDTH-1], sample} + ROUND;

    // Adding a positive constant can only overflow upward: result sign is
    // still positive at DATA_WIDTH+1 bits but the DATA_WIDTH-bit MSB is set.
    assign overflow = ~sum[DATA_WIDTH] & sum[DATA_WIDTH-1];
    assign sat      = overflow ? {1'b0, {(DATA_WIDTH-1){1'b1}}} : sum[DATA_WIDTH-1:0];

    // Offset binary: invert the sign bit, pass the rest of the top bits.
    assign code[DAC_BITS-1] = ~sat[DATA_WIDTH-1];
    generate
        for (genvar gi = 0; gi < DAC_BITS - 1; gi++) begin : g_code
            assign code[gi] = sat[DATA_WIDTH-DAC_BITS+gi];
        end
    endgenerate

    // Bits below DAC resolution are discarded after rounding.
    assign unused_low = ^sat[DATA_WIDTH-DAC_BITS-1:0];

endmodule

// File: rtl/dac_spi_tx.sv
// DAC output stage: accepts signed samples on a valid/ready handshake,
// converts them to offset-binary DAC codes into a one-deep holding register,
// and shifts each out as an SPI mode-0 frame {DAC_CMD, code}, MSB first.
//   ACLK, ARESETN : clock and asynchronous active-low reset
//   s_data/s_valid/s_ready : sample input handshake (ready = holding empty)
//   sclk, cs_n, mosi       : SPI to the DAC, all registered
//   busy                   : frame on the wire or in the CS idle gap
module dac_spi_tx
    import dac_spi_pkg::*;
#(
    parameter int                   DATA_WIDTH = 16,
    parameter int                   DAC_BITS   = 12,
    parameter logic [CMD_BITS-1:0]  DAC_CMD    = DAC_CMD_DEFAULT,
    parameter int                   SCLK_DIV   = 4,
    parameter int                   CS_IDLE    = 2
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic                  sclk,
    output logic                  cs_n,
    output logic                  mosi,
    output logic                  busy
);

    localparam int FRAME_BITS = frame_bits(DAC_BITS);
    localparam int CNT_MAX    = (SCLK_DIV > CS_IDLE) ? SCLK_DIV : CS_IDLE;
    localparam int CNT_W      = $clog2(CNT_MAX + 1);
    localparam int BIT_W      = $clog2(FRAME_BITS);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(SCLK_DIV - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(CS_IDLE - 1);

    dac_state_t              state_reg, state_next;
    logic [CNT_W-1:0]        half_cnt_reg, half_cnt_next;
    logic [BIT_W-1:0]        bit_cnt_reg, bit_cnt_next;
    logic [FRAME_BITS-1:0]   shift_reg, shift_next;
    logic [DAC_BITS-1:0]     hold_data_reg, hold_data_next;
    logic                    hold_full_reg, hold_full_next;
    logic                    sclk_reg, sclk_next;
    logic                    cs_n_reg, cs_n_next;
    logic                    busy_reg, busy_next;

    logic [DAC_BITS-1:0]     conv_code;
    logic                    accept;

    dac_code_conv #(
        .DATA_WIDTH (DATA_WIDTH),
        .DAC_BITS   (DAC_BITS)
    ) u_conv (
        .sample (s_data),
        .code   (conv_code)
    );

    assign accept  = s_valid && !hold_full_reg;
    assign s_ready = !hold_full_reg;
    assign sclk    = sclk_reg;
    assign cs_n    = cs_n_reg;
    assign busy    = busy_reg;
    // The shifter is cleared at frame end, so its MSB doubles as idle-low mosi.
    assign mosi    = shift_reg[FRAME_BITS-1];

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_reg     <= ST_IDLE;
            half_cnt_reg  <= '0;
            bit_cnt_reg   <= '0;
            shift_reg     <= '0;
            hold_data_reg <= '0;
            hold_full_reg <= 1'b0;
            sclk_reg      <= 1'b0;
            cs_n_reg      <= 1'b1;
            busy_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            half_cnt_reg  <= half_cnt_next;
            bit_cnt_reg   <= bit_cnt_next;
            shift_reg     <= shift_next;
            hold_data_reg <= hold_data_next;
            hold_full_reg <= hold_full_next;
            sclk_reg      <= sclk_next;
            cs_n_reg      <= cs_n_next;
            busy_reg      <= busy_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        half_cnt_next  = half_cnt_reg;
        bit_cnt_next   = bit_cnt_reg;
        shift_next     = shift_reg;
        hold_data_next = hold_data_reg;
        hold_full_next = hold_full_reg;
        sclk_next      = sclk_reg;
        cs_n_next      = cs_n_reg;
        busy_next      = busy_reg;

        case (state_reg)
            ST_IDLE: begin
                if (hold_full_reg) begin
                    shift_next     = {DAC_CMD, hold_data_reg};
                    hold_full_next = 1'b0;
                    cs_n_next      = 1'b0;
                    busy_next      = 1'b1;
                    half_cnt_next  = '0;
                    bit_cnt_next   = BIT_W'(FRAME_BITS - 1);
                    state_next     = ST_LOW;
                end
            end
            ST_LOW: begin
                if (half_cnt_reg == HALF_LAST) begin
                    half_cnt_next = '0;
                    sclk_next     = 1'b1;
                    state_next    = ST_HIGH;
                end else begin
                    half_cnt_next = half_cnt_reg + CNT_W'(1);
                end
            end
            ST_HIGH: begin
                if (half_cnt_reg == HALF_LAST) begin
                    half_cnt_next = '0;
                    sclk_next     = 1'b0;
                    if (bit_cnt_reg != '0) begin
                        // Next bit appears on the sclk falling edge.
                        shift_next   = shift_reg << 1;
                        bit_cnt_next = bit_cnt_reg - BIT_W'(1);
                        state_next   = ST_LOW;
                    end else begin
                        shift_next = '0;
                        cs_n_next  = 1'b1;
                        state_next = ST_GAP;
                    end
                end else begin
                    half_cnt_next = half_cnt_reg + CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (half_cnt_reg == GAP_LAST) begin
                    half_cnt_next = '0;
                    busy_next     = 1'b0;
                    state_next    = ST_IDLE;
                end else begin
                    half_cnt_next = half_cnt_reg + CNT_W'(1);
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // Accept only when empty, so an IDLE load in the same cycle can
        // never coincide with a handshake; ordering after the load keeps
        // the register-fill semantics obvious anyway.
        if (accept) begin
            hold_data_next = conv_code;
            hold_full_next = 1'b1;
        end
    end

endmodule

// File: tb/tb_dac_spi_tx.sv
// Directed bench for dac_spi_tx: a default build (SCLK_DIV=4, CS_IDLE=2) and
// a fast build (SCLK_DIV=1, CS_IDLE=1). A monitor reassembles SPI frames and
// frame timing; the main sequence compares them with hand-computed values.
module tb_dac_spi_tx;

    logic        ACLK;
    logic        ARESETN;
    logic [15:0] s_data  [2];
    logic        s_valid [2];
    logic        s_ready [2];
    logic        sclk_w  [2];
    logic        cs_n_w  [2];
    logic        mosi_w  [2];
    logic        busy_w  [2];

    int n_tests = 0;
    int n_fail  = 0;

    dac_spi_tx u_dut (
        .ACLK    (ACLK),
        .ARESETN (ARESETN),
        .s_data  (s_data[0]),
        .s_valid (s_valid[0]),
        .s_ready (s_ready[0]),
        .sclk    (sclk_w[0]),
        .cs_n    (cs_n_w[0]),
        .mosi    (mosi_w[0]),
        .busy    (busy_w[0])
    );

    dac_spi_tx #(.SCLK_DIV(1), .CS_IDLE(1)) u_dut_fast (
        .ACLK    (ACLK),
        .ARESETN (ARESETN),
        .s_data  (s_data[1]),
        .s_valid (s_valid[1]),
        .s_ready (s_ready[1]),
        .sclk    (sclk_w[1]),
        .cs_n    (cs_n_w[1]),
        .mosi    (mosi_w[1]),
        .busy    (busy_w[1])
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- frame monitor ----------------
    typedef struct {
        logic [15:0] frame;
        int nbits;
        int low_len;
        int min_sp;
        int max_sp;
        int min_age;
        int viol;
        int gap;
        int fall_cyc;
    } rec_t;

    rec_t q0[$];
    rec_t q1[$];

    int          cyc = 0;
    int          nb[2], start_c[2], minsp[2], maxsp[2], minage[2], viol[2];
    int          last_rise[2], last_chg[2], rise_cyc[2], fall_c[2], falls[2], gap_c[2];
    logic [15:0] sh[2];
    bit          in_frame[2];
    logic        prev_cs[2], prev_sclk[2], prev_mosi[2];

    initial begin
        for (int i = 0; i < 2; i++) begin
            prev_cs[i] = 1'b1; prev_sclk[i] = 1'b0; prev_mosi[i] = 1'b0;
            in_frame[i] = 1'b0; falls[i] = 0; rise_cyc[i] = -1000; last_chg[i] = -1000;
            nb[i] = 0;
        end
        forever begin
            @(negedge ACLK);
            cyc++;
            for (int i = 0; i < 2; i++) begin
                if (!ARESETN) begin
                    in_frame[i] = 1'b0;
                end else begin
                    if (prev_cs[i] && !cs_n_w[i]) begin
                        in_frame[i] = 1'b1;
                        nb[i] = 0; sh[i] = '0; start_c[i] = cyc;
                        minsp[i] = 99999; maxsp[i] = 0; minage[i] = 99999; viol[i] = 0;
                        gap_c[i] = cyc - rise_cyc[i]; fall_c[i] = cyc; falls[i]++;
                    end
                    if (mosi_w[i] !== prev_mosi[i]) begin
                        if (in_frame[i] && !(prev_sclk[i] && !sclk_w[i]) && !(prev_cs[i] && !cs_n_w[i]))
                            viol[i]++;
                        last_chg[i] = cyc;
                    end
                    if (in_frame[i] && !prev_sclk[i] && sclk_w[i]) begin
                        sh[i] = {sh[i][14:0], mosi_w[i]};
                        if (nb[i] > 0) begin
                            if (cyc - last_rise[i] < minsp[i]) minsp[i] = cyc - last_rise[i];
                            if (cyc - last_rise[i] > maxsp[i]) maxsp[i] = cyc - last_rise[i];
                        end
                        if (cyc - last_chg[i] < minage[i]) minage[i] = cyc - last_chg[i];
                        last_rise[i] = cyc;
                        nb[i]++;
                    end
                    if (in_frame[i] && !prev_cs[i] && cs_n_w[i]) begin
                        rec_t r;
                        r.frame = sh[i]; r.nbits = nb[i]; r.low_len = cyc - start_c[i];
                        r.min_sp = minsp[i]; r.max_sp = maxsp[i]; r.min_age = minage[i];
                        r.viol = viol[i]; r.gap = gap_c[i]; r.fall_cyc = fall_c[i];
                        if (i == 0) q0.push_back(r); else q1.push_back(r);
                        in_frame[i] = 1'b0;
                        rise_cyc[i] = cyc;
                    end
                end
                prev_cs[i] = cs_n_w[i]; prev_sclk[i] = sclk_w[i]; prev_mosi[i] = mosi_w[i];
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic int qsize(input int i);
        return (i == 0) ? q0.size() : q1.size();
    endfunction

    // Present a sample and hold s_valid until the handshake edge; returns the
    // monitor cycle number of the sample just after the accepting edge.
    task automatic send(input int i, input logic [15:0] d, output int acc_cyc);
        bit done = 1'b0;
        acc_cyc = -1;
        s_data[i]  = d;
        s_valid[i] = 1'b1;
        for (int t = 0; t < 3000 && !done; t++) begin
            if (s_ready[i]) begin
                @(posedge ACLK);
                acc_cyc = cyc + 1;
                done = 1'b1;
            end else begin
                @(negedge ACLK); #1;
            end
        end
        if (!done) check("send_timeout", 32'd0, 32'd1);
        @(negedge ACLK); #1;
    endtask

    task automatic wait_frames(input int i, input int n);
        int t = 0;
        while (qsize(i) < n && t < 5000) begin
            @(negedge ACLK); #1;
            t++;
        end
        if (qsize(i) < n) check("frame_timeout", qsize(i), n);
    endtask

    task automatic wait_idle(input int i);
        int t = 0;
        while (busy_w[i] && t < 1000) begin
            @(negedge ACLK); #1;
            t++;
        end
        check("idle_timeout", busy_w[i], 1'b0);
    endtask

    task automatic pop(input int i, output rec_t r);
        r = '{16'hxxxx, 0, 0, 0, 0, 0, 0, 0, 0};
        if (qsize(i) == 0) check("queue_empty", 32'd0, 32'd1);
        else if (i == 0) r = q0.pop_front();
        else r = q1.pop_front();
    endtask

    // Checks the next captured frame; full timing checks when 'timing' is set.
    task automatic check_frame(input int i, input string name, input logic [15:0] exp,
                               input bit timing);
        rec_t r;
        int div;
        div = (i == 0) ? 4 : 1;
        pop(i, r);
        $display("[TB] dut%0d %s frame=0x%04h bits=%0d cs_low=%0d", i, name, r.frame, r.nbits, r.low_len);
        check({name, "_frame"}, r.frame, exp);
        check({name, "_cs_low"}, r.low_len, 16 * 2 * div);
        if (timing) begin
            check({name, "_nbits"}, r.nbits, 16);
            check({name, "_min_sp"}, r.min_sp, 2 * div);
            check({name, "_max_sp"}, r.max_sp, 2 * div);
            check({name, "_setup"}, (r.min_age >= div), 1'b1);
            check({name, "_mosi_chg"}, r.viol, 0);
        end
    endtask

    // ---------------- main sequence ----------------
    logic [15:0] vin  [5] = '{16'h7FFF, 16'h8000, 16'h0017, 16'hFFF7, 16'h7FF9};
    logic [15:0] vexp [5] = '{16'h3FFF, 16'h3000, 16'h3801, 16'h37FF, 16'h3FFF};

    initial begin
        int a1, a2, a3, f0, sz0, t;
        rec_t r1, r2, r3;

        ARESETN = 1'b0;
        for (int i = 0; i < 2; i++) begin
            s_valid[i] = 1'b0;
            s_data[i]  = '0;
        end
        repeat (3) @(negedge ACLK);
        #1;
        for (int i = 0; i < 2; i++) begin
            check("rst_sclk", sclk_w[i], 1'b0);
            check("rst_cs_n", cs_n_w[i], 1'b1);
            check("rst_mosi", mosi_w[i], 1'b0);
            check("rst_busy", busy_w[i], 1'b0);
            check("rst_s_ready", s_ready[i], 1'b1);
        end
        ARESETN = 1'b1;
        repeat (2) @(negedge ACLK);
        #1;

        // Fast build: one frame, sclk toggles every cycle.
        send(1, 16'h0000, a1);
        s_valid[1] = 1'b0;
        wait_frames(1, 1);
        check_frame(1, "fast_zero", 16'h3800, 1'b1);
        wait_idle(1);

        // Default build: single sample with latency and full timing checks.
        send(0, 16'h0000, a1);
        check("acc_s_ready_low", s_ready[0], 1'b0);
        check("acc_cs_n_still_high", cs_n_w[0], 1'b1);
        s_valid[0] = 1'b0;
        @(negedge ACLK); #1;
        check("load_cs_n_low", cs_n_w[0], 1'b0);
        check("load_busy", busy_w[0], 1'b1);
        check("load_s_ready_high", s_ready[0], 1'b1);
        wait_frames(0, 1);
        check_frame(0, "zero", 16'h3800, 1'b1);
        wait_idle(0);

        // Conversion vectors: full scale, rounding and saturation.
        for (int k = 0; k < 5; k++) begin
            send(0, vin[k], a1);
            s_valid[0] = 1'b0;
            wait_frames(0, 1);
            check_frame(0, $sformatf("vec%0d", k), vexp[k], 1'b0);
            wait_idle(0);
        end

        // Back-to-back with s_valid held high.
        send(0, 16'h0000, a1);
        send(0, 16'h7FFF, a2);
        send(0, 16'h8000, a3);
        s_valid[0] = 1'b0;
        wait_frames(0, 3);
        pop(0, r1);
        pop(0, r2);
        pop(0, r3);
        $display("[TB] dut0 b2b frames=0x%04h 0x%04h 0x%04h gaps=%0d %0d", r1.frame, r2.frame, r3.frame, r2.gap, r3.gap);
        check("b2b_f1", r1.frame, 16'h3800);
        check("b2b_f2", r2.frame, 16'h3FFF);
        check("b2b_f3", r3.frame, 16'h3000);
        check("b2b_lat1", r1.fall_cyc - a1, 1);
        check("b2b_acc2_after_load1", a2 - r1.fall_cyc, 1);
        check("b2b_acc3_after_load2", a3 - r2.fall_cyc, 1);
        check("b2b_gap2", r2.gap, 3);
        check("b2b_gap3", r3.gap, 3);
        check("b2b_cs_low3", r3.low_len, 128);
        wait_idle(0);

        // Reset mid-frame with the holding register full.
        send(0, 16'h7FFF, a1);
        send(0, 16'h0017, a2);
        s_valid[0] = 1'b0;
        t = 0;
        while (!(in_frame[0] && nb[0] >= 7) && t < 1000) begin
            @(negedge ACLK); #1;
            t++;
        end
        check("mid_reached_bit7", nb[0], 7);
        check("mid_hold_full", s_ready[0], 1'b0);
        #1;
        ARESETN = 1'b0;
        #1;
        check("mid_rst_cs_n", cs_n_w[0], 1'b1);
        check("mid_rst_sclk", sclk_w[0], 1'b0);
        check("mid_rst_mosi", mosi_w[0], 1'b0);
        check("mid_rst_busy", busy_w[0], 1'b0);
        check("mid_rst_s_ready", s_ready[0], 1'b1);
        repeat (2) @(negedge ACLK);
        #1;
        ARESETN = 1'b1;
        f0  = falls[0];
        sz0 = q0.size();
        repeat (300) @(negedge ACLK);
        #1;
        check("post_rst_no_cs_fall", falls[0] - f0, 0);
        check("post_rst_no_frame", q0.size() - sz0, 0);
        check("post_rst_cs_n", cs_n_w[0], 1'b1);
        send(0, 16'h8000, a1);
        s_valid[0] = 1'b0;
        wait_frames(0, 1);
        check_frame(0, "post_rst", 16'h3000, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
